l2_mem_arbiter: RTL and testbench

- Sits directly downstream of the L2 cache.
- Merges the L2's independent instruction-side (memi_*) and data-side (memd_*) line-refill/writeback ports onto the single shared 128-bit line memory port.
- Serialises requests with fair arbitration, latches each transaction, and returns read data on a per-port registered buffer.
- Each port buffer holds its data stable after the ready pulse, so the L2 can consume it in its post-ready state.

---
 rtl/l2_mem_arbiter_pkg.sv | 18 +
 rtl/l2_mem_arbiter_arb_rr2.sv | 36 +++
 rtl/l2_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_l2_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_mem_arbiter_pkg.sv
// Shared types and defaults for the L2 line-memory arbiter.
// Widths are shared with the L2 and the memory model.
package l2_mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;

endpackage

// File: rtl/l2_mem_arbiter_arb_rr2.sv
// Two-way grant selection with last-grant memory.
// ARB_D_PRIORITY_EN selects fixed D-first priority instead.
module arb_rr2
  import l2_mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic i_rst,
  input  logic i_req_i,
  input  logic i_req_d,
  input  logic i_take,
  output logic o_sel
);

`ifdef ARB_D_PRIORITY_EN
  logic w_unused;
  assign w_unused = ^{clk, i_rst, i_take, i_req_i};
  assign o_sel    = i_req_d ? SEL_D : SEL_I;
`else
  logic r_last;

  always_ff @(posedge clk) begin
    if (i_rst)
      r_last <= SEL_I;
    else if (i_take)
      r_last <= o_sel;
  end

  // On a tie the port that did not win last time goes first.
  always_comb begin
    o_sel = i_req_d ? SEL_D : SEL_I;
    if (i_req_i && i_req_d)
      o_sel = ~r_last;
  end
`endif

endmodule

// File: rtl/l2_mem_arbiter.sv
// Merges the L2 I-side and D-side line ports onto one memory port.
// Build option: ARB_D_PRIORITY_EN (fixed D-first arbitration).
module l2_mem_arbiter
  import l2_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              memi_read,
  input  logic              memi_write,
  input  logic [ADDR_W-1:0] memi_addr,
  input  logic [DATA_W-1:0] memi_wdata,
  output logic [DATA_W-1:0] memi_rdata,
  output logic              memi_ready,
  input  logic              memd_read,
  input  logic              memd_write,
  input  logic [ADDR_W-1:0] memd_addr,
  input  logic [DATA_W-1:0] memd_wdata,
  output logic [DATA_W-1:0] memd_rdata,
  output logic              memd_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_t              r_state;
  logic                r_mem_read;
  logic                r_mem_write;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_rdata_i;
  logic [DATA_W-1:0]   r_rdata_d;
  logic                r_ready_i;
  logic                r_ready_d;

  logic w_req_i;
  logic w_req_d;
  logic w_any;
  logic w_take;
  logic w_sel;

  assign w_req_i = memi_read | memi_write;
  assign w_req_d = memd_read | memd_write;
  assign w_any   = w_req_i | w_req_d;
  assign w_take  = (r_state == IDLE) && w_any;

  arb_rr2 u_arb (
    .clk     (clk),
    .i_rst   (proc_reset),
    .i_req_i (w_req_i),
    .i_req_d (w_req_d),
    .i_take  (w_take),
    .o_sel   (w_sel)
  );

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_state     <= IDLE;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata_i   <= '0;
      r_rdata_d   <= '0;
      r_ready_i   <= 1'b0;
      r_ready_d   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            // Write wins when an L2 port raises both strobes.
            if (w_sel == SEL_D) begin
              r_mem_write <= memd_write;
              r_mem_read  <= memd_read & ~memd_write;
              r_mem_addr  <= memd_addr;
              r_mem_wdata <= memd_wdata;
              r_state     <= BUSY_D;
            end else begin
              r_mem_write <= memi_write;
              r_mem_read  <= memi_read & ~memi_write;
              r_mem_addr  <= memi_addr;
              r_mem_wdata <= memi_wdata;
              r_state     <= BUSY_I;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready) begin
            if (r_mem_read) begin
              if (r_state == BUSY_I)
                r_rdata_i <= mem_rdata;
              else
                r_rdata_d <= mem_rdata;
            end
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_ready_i   <= (r_state == BUSY_I);
            r_ready_d   <= (r_state == BUSY_D);
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_ready_i <= 1'b0;
          r_ready_d <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign memi_rdata = r_rdata_i;
  assign memd_rdata = r_rdata_d;
  assign memi_ready = r_ready_i;
  assign memd_ready = r_ready_d;

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Directed self-checking bench for l2_mem_arbiter.
module tb_l2_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  localparam logic [DW-1:0] DA5 = {16{8'hA5}};
  localparam logic [DW-1:0] W1  = {4{32'h1111_2222}};
  localparam logic [DW-1:0] W2  = {4{32'h3333_4444}};
  localparam logic [DW-1:0] R1  = {4{32'hC0DE_0001}};
  localparam logic [DW-1:0] R2  = {4{32'hC0DE_0002}};
  localparam logic [DW-1:0] R3  = {4{32'hC0DE_0003}};
  localparam logic [DW-1:0] JNK = {4{32'hDEAD_BEEF}};

  logic          clk = 1'b0;
  logic          proc_reset;
  logic          memi_read, memi_write;
  logic [AW-1:0] memi_addr;
  logic [DW-1:0] memi_wdata, memi_rdata;
  logic          memi_ready;
  logic          memd_read, memd_write;
  logic [AW-1:0] memd_addr;
  logic [DW-1:0] memd_wdata, memd_rdata;
  logic          memd_ready;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ready;

  int checks = 0;
  int errors = 0;
  int d_pulses = 0;
  int snap;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (memd_ready) d_pulses++;

  l2_mem_arbiter dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .memi_read  (memi_read),
    .memi_write (memi_write),
    .memi_addr  (memi_addr),
    .memi_wdata (memi_wdata),
    .memi_rdata (memi_rdata),
    .memi_ready (memi_ready),
    .memd_read  (memd_read),
    .memd_write (memd_write),
    .memd_addr  (memd_addr),
    .memd_wdata (memd_wdata),
    .memd_rdata (memd_rdata),
    .memd_ready (memd_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    proc_reset = 1'b1;
    step();
    step();
    proc_reset = 1'b0;
  endtask

  initial begin
    proc_reset = 1'b1;
    memi_read = 0; memi_write = 0; memi_addr = '0; memi_wdata = '0;
    memd_read = 0; memd_write = 0; memd_addr = '0; memd_wdata = '0;
    mem_rdata = '0; mem_ready = 0;
    do_reset();

    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_ready_i", memi_ready, 0);
    chk("rst_ready_d", memd_ready, 0);
    chk("rst_rdata_i", memi_rdata, 0);
    chk("rst_rdata_d", memd_rdata, 0);

    // I read alone, memory answers after k=2
    memi_read = 1; memi_addr = 28'h0000123;
    step();
    chk("ird_mem_read", mem_read, 1);
    chk("ird_mem_write", mem_write, 0);
    chk("ird_mem_addr", mem_addr, 28'h0000123);
    step();
    chk("ird_wait_ready", memi_ready, 0);
    step();
    chk("ird_hold_read", mem_read, 1);
    mem_ready = 1; mem_rdata = DA5;
    step();
    mem_ready = 0; mem_rdata = JNK;
    chk("ird_ready", memi_ready, 1);
    chk("ird_rdata", memi_rdata, DA5);
    chk("ird_strobe_off", mem_read, 0);
    chk("ird_no_d_ready", memd_ready, 0);
    memi_read = 0;
    step();
    chk("ird_ready_pulse", memi_ready, 0);
    chk("ird_rdata_held", memi_rdata, DA5);
    chk("ird_idle", mem_read, 0);

    // Simultaneous I read + D write after reset: D first
    do_reset();
    memi_read = 1; memi_addr = 28'h55;
    memd_write = 1; memd_addr = 28'h66; memd_wdata = W1;
    step();
    chk("tie1_d_write", mem_write, 1);
    chk("tie1_d_noread", mem_read, 0);
    chk("tie1_d_addr", mem_addr, 28'h66);
    chk("tie1_d_wdata", mem_wdata, W1);
    mem_ready = 1; mem_rdata = JNK;
    step();
    mem_ready = 0;
    chk("tie1_d_ready", memd_ready, 1);
    chk("tie1_i_notready", memi_ready, 0);
    chk("tie1_wr_no_capture", memd_rdata, 0);
    // D raises a new request at once: new tie, I now goes first
    memd_write = 0; memd_read = 1; memd_addr = 28'h77;
    step();
    chk("tie2_idle_gap", mem_read | mem_write, 0);
    step();
    chk("tie2_i_read", mem_read, 1);
    chk("tie2_i_addr", mem_addr, 28'h55);
    mem_ready = 1; mem_rdata = R1;
    step();
    mem_ready = 0;
    chk("tie2_i_ready", memi_ready, 1);
    chk("tie2_i_rdata", memi_rdata, R1);
    chk("tie2_d_wait", memd_ready, 0);
    memi_read = 0;
    step();
    chk("tie2_gap2", mem_read, 0);
    step();
    chk("tie2_d_read", mem_read, 1);
    chk("tie2_d_addr", mem_addr, 28'h77);
    mem_ready = 1; mem_rdata = R2;
    step();
    mem_ready = 0;
    chk("tie2_d_ready", memd_ready, 1);
    chk("tie2_d_rdata", memd_rdata, R2);
    chk("tie2_i_rdata_kept", memi_rdata, R1);
    memd_read = 0;
    step();

    // Writeback then refill on the D port
    snap = d_pulses;
    memd_write = 1; memd_addr = 28'h10; memd_wdata = W2;
    step();
    chk("wb_write", mem_write, 1);
    chk("wb_addr", mem_addr, 28'h10);
    chk("wb_wdata", mem_wdata, W2);
    mem_ready = 1; mem_rdata = JNK;
    step();
    mem_ready = 0;
    chk("wb_ready", memd_ready, 1);
    chk("wb_rdata_kept", memd_rdata, R2);
    memd_write = 0; memd_read = 1; memd_addr = 28'h20;
    step();
    chk("wb_gap", mem_read | mem_write, 0);
    chk("wb_ready_off", memd_ready, 0);
    step();
    chk("rf_read", mem_read, 1);
    chk("rf_addr", mem_addr, 28'h20);
    mem_ready = 1; mem_rdata = R3;
    step();
    mem_ready = 0;
    chk("rf_ready", memd_ready, 1);
    chk("rf_rdata", memd_rdata, R3);
    memd_read = 0;
    step();
    step();
    chk("wbrf_pulses", d_pulses - snap, 2);

    // k=0 round trip; request held through DONE must not regrant
    memi_read = 1; memi_addr = 28'h0ABCDEF;
    mem_ready = 1; mem_rdata = R1;
    step();
    chk("k0_read", mem_read, 1);
    chk("k0_not_yet", memi_ready, 0);
    mem_ready = 1; mem_rdata = DA5;
    step();
    mem_ready = 0;
    chk("k0_ready", memi_ready, 1);
    chk("k0_rdata", memi_rdata, DA5);
    step();
    chk("k0_no_regrant", mem_read, 0);
    chk("k0_ready_off", memi_ready, 0);
    memi_read = 0;
    step();
    chk("k0_idle", mem_read, 0);

    // Reset during BUSY_D aborts the transaction
    memd_read = 1; memd_addr = 28'h30;
    step();
    chk("abort_busy", mem_read, 1);
    step();
    proc_reset = 1;
    step();
    proc_reset = 0; memd_read = 0;
    chk("abort_read", mem_read, 0);
    chk("abort_write", mem_write, 0);
    chk("abort_ready_d", memd_ready, 0);
    chk("abort_rdata_i", memi_rdata, 0);
    chk("abort_rdata_d", memd_rdata, 0);
    chk("abort_addr", mem_addr, 0);
    step();
    chk("abort_no_ready", memd_ready, 0);
    chk("abort_idle", mem_read, 0);

`ifdef ARB_D_PRIORITY_EN
    // Three back-to-back ties: D wins every one
    memi_read = 1; memi_addr = 28'h1;
    memd_write = 1; memd_addr = 28'h2; memd_wdata = W1;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("prio_d_write", mem_write, 1);
      chk("prio_d_noread", mem_read, 0);
      mem_ready = 1;
      step();
      mem_ready = 0;
      chk("prio_d_ready", memd_ready, 1);
      step();
    end
    memd_write = 0;
    step();
    chk("prio_i_last", mem_read, 1);
    chk("prio_i_addr", mem_addr, 28'h1);
    mem_ready = 1; mem_rdata = R3;
    step();
    mem_ready = 0; memi_read = 0;
    chk("prio_i_ready", memi_ready, 1);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
